aes_enc_core_dp_onchip_memory: RTL

//  Parametrised true-dual-port on-chip RAM for the AES encryption core. Two independent

---
 rtl/aes_enc_core_dp_onchip_memory.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/aes_enc_core_dp_onchip_memory.sv
// True dual-port RAM for the AES core buffers: two Avalon-MM slaves,
// configurable read latency, stall handling and post-reset zero-fill.
module aes_enc_core_dp_onchip_memory #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 13,
   parameter int DEPTH          = 8192,
   parameter int READ_LATENCY   = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                clken,
   input  logic                reset_req,
   input  logic                a_chipselect,
   input  logic                a_read,
   input  logic                a_write,
   input  logic [ADDR_W-1:0]   a_address,
   input  logic [DATA_W/8-1:0] a_byteenable,
   input  logic [DATA_W-1:0]   a_writedata,
   output logic [DATA_W-1:0]   a_readdata,
   output logic                a_readdatavalid,
   output logic                a_waitrequest,
   input  logic                b_chipselect,
   input  logic                b_read,
   input  logic                b_write,
   input  logic [ADDR_W-1:0]   b_address,
   input  logic [DATA_W/8-1:0] b_byteenable,
   input  logic [DATA_W-1:0]   b_writedata,
   output logic [DATA_W-1:0]   b_readdata,
   output logic                b_readdatavalid,
   output logic                b_waitrequest,
   output logic                init_done
);
   localparam int NB = DATA_W / 8;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);
   localparam logic [IW-1:0]   LP_LAST  = IW'(DEPTH - 1);
   localparam logic            LP_CLR   = (CLEAR_ON_RESET != 0);

   typedef enum logic [1:0] {S_RESET, S_CLEAR, S_READY} state_t;

   state_t          r_state;
   state_t          w_next;
   logic [IW-1:0]   r_cnt;
   logic            w_stall;
   logic            w_busy;
   logic            w_clr;
   logic            w_rdy;
   logic            w_wait;

   logic [DATA_W-1:0] r_mem [DEPTH];

   assign w_stall = ~clken | reset_req;
   assign w_wait  = w_stall | w_busy;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_state <= S_RESET;
      else if (!w_stall)
         r_state <= w_next;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_cnt <= '0;
      else if (!w_stall)
         r_cnt <= (r_state == S_CLEAR) ? r_cnt + 1'b1 : '0;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_RESET: w_next = LP_CLR ? S_CLEAR : S_READY;
         S_CLEAR: if (r_cnt == LP_LAST) w_next = S_READY;
         default: w_next = S_READY;
      endcase
   end

   always_comb begin
      w_busy = 1'b0;
      w_clr  = 1'b0;
      w_rdy  = 1'b0;
      unique case (r_state)
         S_RESET: w_busy = LP_CLR;
         S_CLEAR: begin
            w_busy = 1'b1;
            w_clr  = ~w_stall;
         end
         default: w_rdy = 1'b1;
      endcase
   end

   assign init_done     = w_rdy;
   assign a_waitrequest = w_wait;
   assign b_waitrequest = w_wait;

   logic            w_a_inr, w_a_acc, w_a_we, w_a_re;
   logic            w_b_inr, w_b_acc, w_b_we, w_b_re;
   logic [IW-1:0]   w_a_idx, w_b_idx, w_pa_idx;
   logic            w_pa_we;
   logic [NB-1:0]   w_pa_be;
   logic [DATA_W-1:0] w_pa_wd;

   assign w_a_inr = {1'b0, a_address} < LP_DEPTH;
   assign w_a_acc = a_chipselect & (a_read | a_write) & ~w_wait;
   assign w_a_we  = w_a_acc & a_write & w_a_inr;
   assign w_a_re  = w_a_acc & a_read & ~a_write;
   assign w_a_idx = a_address[IW-1:0];

   assign w_b_inr = {1'b0, b_address} < LP_DEPTH;
   assign w_b_acc = b_chipselect & (b_read | b_write) & ~w_wait;
   assign w_b_we  = w_b_acc & b_write & w_b_inr;
   assign w_b_re  = w_b_acc & b_read & ~b_write;
   assign w_b_idx = b_address[IW-1:0];

   // The zero-fill borrows the port-A write path; users are held off meanwhile
   assign w_pa_we  = w_clr | w_a_we;
   assign w_pa_idx = w_clr ? r_cnt : w_a_idx;
   assign w_pa_be  = w_clr ? '1 : a_byteenable;
   assign w_pa_wd  = w_clr ? '0 : a_writedata;

   // A is applied last so it wins on lanes both ports enable
   always_ff @(posedge clk) begin
      for (int l = 0; l < NB; l++) begin
         if (w_b_we && b_byteenable[l])
            r_mem[w_b_idx][l*8 +: 8] <= b_writedata[l*8 +: 8];
         if (w_pa_we && w_pa_be[l])
            r_mem[w_pa_idx][l*8 +: 8] <= w_pa_wd[l*8 +: 8];
      end
   end

   logic [DATA_W-1:0]       r_a_d [READ_LATENCY];
   logic [DATA_W-1:0]       r_b_d [READ_LATENCY];
   logic [READ_LATENCY-1:0] r_a_v;
   logic [READ_LATENCY-1:0] r_b_v;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_a_v <= '0;
         r_b_v <= '0;
         for (int k = 0; k < READ_LATENCY; k++) begin
            r_a_d[k] <= '0;
            r_b_d[k] <= '0;
         end
      end else if (!w_stall) begin
         r_a_v[0] <= w_a_re;
         r_b_v[0] <= w_b_re;
         if (w_a_re)
            r_a_d[0] <= w_a_inr ? r_mem[w_a_idx] : '0;
         if (w_b_re)
            r_b_d[0] <= w_b_inr ? r_mem[w_b_idx] : '0;
         for (int k = 1; k < READ_LATENCY; k++) begin
            r_a_v[k] <= r_a_v[k-1];
            r_b_v[k] <= r_b_v[k-1];
            if (r_a_v[k-1])
               r_a_d[k] <= r_a_d[k-1];
            if (r_b_v[k-1])
               r_b_d[k] <= r_b_d[k-1];
         end
      end
   end

   assign a_readdata      = r_a_d[READ_LATENCY-1];
   assign b_readdata      = r_b_d[READ_LATENCY-1];
   assign a_readdatavalid = r_a_v[READ_LATENCY-1] & ~w_stall;
   assign b_readdatavalid = r_b_v[READ_LATENCY-1] & ~w_stall;

endmodule
